// File: rtl/inst_mem_loader_pkg.sv
// Shared constants and FSM encoding for the instruction-memory loader.
package inst_mem_loader_pkg;

  localparam int DEF_S_DATA_W = 512;
  localparam int DEF_INST_LEN = 32;
  localparam int DEF_LEN_W    = 17;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_FILL  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Number of instruction lanes carried by one stream beat.
  function automatic int lanes_of(input int data_w, input int inst_w);
    return data_w / inst_w;
  endfunction

endpackage

// File: rtl/inst_beat_slicer.sv
// Holds one stream beat and walks its instruction lanes in order.
// On load the incoming beat is captured and lane 0 is presented straight
// from the bus so the first strobe needs no extra cycle; lane_idx then
// points at the next lane to emit.
module inst_beat_slicer
  import inst_mem_loader_pkg::*;
#(
  parameter int S_DATA_W = DEF_S_DATA_W,
  parameter int INST_LEN = DEF_INST_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                advance,
  input  logic [S_DATA_W-1:0] tdata,
  output logic [INST_LEN-1:0] word,
  output logic                lanes_done
);

  localparam int LANES = lanes_of(S_DATA_W, INST_LEN);
  localparam int IDX_W = $clog2(LANES + 1);

  logic [S_DATA_W-1:0] beat_q, beat_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  // Next beat register and lane index.
  always_comb begin
    beat_d = beat_q;
    idx_d  = idx_q;
    if (load) begin
      beat_d = tdata;
      idx_d  = IDX_W'(1);
    end else if (advance) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  // Beat storage and lane index flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      idx_q  <= '0;
    end else begin
      beat_q <= beat_d;
      idx_q  <= idx_d;
    end
  end

  // LANES:1 word mux; lane 0 bypasses the register on load.
  always_comb begin
    word = '0;
    if (load) begin
      word = tdata[INST_LEN-1:0];
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (idx_q == IDX_W'(i)) word = beat_q[i*INST_LEN +: INST_LEN];
      end
    end
  end

  // All lanes of the held beat have been emitted.
  always_comb lanes_done = (idx_q == IDX_W'(LANES));

endmodule

// File: rtl/inst_mem_loader.sv
// Streams a program into the instruction memory: pulses the memory's
// write-address reset, then slices wide host beats into one write strobe
// per 32-bit instruction, and reports busy/done/error status.
//
// Stream handshake: a beat transfers on a rising clock edge where
// i_s_tvalid and o_s_tready are both 1. o_s_tready is a registered output
// that is high only while waiting for a beat (FILL), so at most one beat is
// ever held and the upstream must keep tdata/tlast stable while tvalid is
// high and no transfer has occurred.
//
// Every output is registered from the next-state decode, so each output
// reflects the state the FSM is in during that cycle.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int S_DATA_W = DEF_S_DATA_W,
  parameter int INST_LEN = DEF_INST_LEN,
  parameter int LEN_W    = DEF_LEN_W
) (
  input  logic                i_sys_clk,
  input  logic                i_sys_rst_n,
  input  logic                i_load_start,
  input  logic [LEN_W-1:0]    i_load_len,
  input  logic [S_DATA_W-1:0] i_s_tdata,
  input  logic                i_s_tvalid,
  input  logic                i_s_tlast,
  output logic                o_s_tready,
  output logic [INST_LEN-1:0] o_inst_mem_data,
  output logic                o_inst_mem_wr_en,
  output logic                o_inst_mem_rst,
  output logic                o_load_busy,
  output logic                o_load_done,
  output logic                o_load_err,
  output logic [LEN_W-1:0]    o_word_count,
  output state_e              o_dbg_state
);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic                err_q, err_d;
  logic                tlast_q, tlast_d;
  logic [INST_LEN-1:0] data_q, data_d;
  logic                wr_en_q, wr_en_d;
  logic                mem_rst_q, mem_rst_d;
  logic                tready_q, tready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                slice_load;
  logic                slice_advance;
  logic [INST_LEN-1:0] slice_word;
  logic                slice_lanes_done;

  inst_beat_slicer #(
    .S_DATA_W(S_DATA_W),
    .INST_LEN(INST_LEN)
  ) u_slicer (
    .clk       (i_sys_clk),
    .rst_n     (i_sys_rst_n),
    .load      (slice_load),
    .advance   (slice_advance),
    .tdata     (i_s_tdata),
    .word      (slice_word),
    .lanes_done(slice_lanes_done)
  );

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    count_d       = count_q;
    err_d         = err_q;
    tlast_d       = tlast_q;
    data_d        = data_q;
    wr_en_d       = 1'b0;
    slice_load    = 1'b0;
    slice_advance = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_load_start) begin
          len_d   = i_load_len;
          count_d = '0;
          err_d   = 1'b0;
          state_d = ST_CLR;
        end
      end
      ST_CLR: begin
        state_d = (len_q == '0) ? ST_DONE : ST_FILL;
      end
      ST_FILL: begin
        if (i_s_tvalid && tready_q) begin
          slice_load = 1'b1;
          tlast_d    = i_s_tlast;
          wr_en_d    = 1'b1;
          data_d     = slice_word;
          count_d    = count_q + LEN_W'(1);
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (count_q == len_q) begin
          // Program complete; leftover lanes are dropped.
          if (!tlast_q) err_d = 1'b1;
          state_d = ST_DONE;
        end else if (slice_lanes_done) begin
          if (tlast_q) begin
            // Stream ended before the requested length.
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          slice_advance = 1'b1;
          wr_en_d       = 1'b1;
          data_d        = slice_word;
          count_d       = count_q + LEN_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_rst_d = (state_d == ST_CLR);
    tready_d  = (state_d == ST_FILL);
    busy_d    = (state_d == ST_CLR) || (state_d == ST_FILL) || (state_d == ST_DRAIN);
    done_d    = (state_d == ST_DONE);
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      tlast_q   <= 1'b0;
      data_q    <= '0;
      wr_en_q   <= 1'b0;
      mem_rst_q <= 1'b0;
      tready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      count_q   <= count_d;
      err_q     <= err_d;
      tlast_q   <= tlast_d;
      data_q    <= data_d;
      wr_en_q   <= wr_en_d;
      mem_rst_q <= mem_rst_d;
      tready_q  <= tready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_s_tready       = tready_q;
  assign o_inst_mem_data  = data_q;
  assign o_inst_mem_wr_en = wr_en_q;
  assign o_inst_mem_rst   = mem_rst_q;
  assign o_load_busy      = busy_q;
  assign o_load_done      = done_q;
  assign o_load_err       = err_q;
  assign o_word_count     = count_q;
  assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: table of load scenarios plus a
// hand-written mid-load reset sequence.
module tb_inst_mem_loader;
  import inst_mem_loader_pkg::*;

  localparam int W     = 32;
  localparam int DW    = 512;
  localparam int LW    = 17;
  localparam int LANES = DW / W;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          i_load_start = 1'b0;
  logic [LW-1:0] i_load_len = '0;
  logic [DW-1:0] i_s_tdata = '0;
  logic          i_s_tvalid = 1'b0;
  logic          i_s_tlast = 1'b0;
  logic          o_s_tready;
  logic [W-1:0]  o_inst_mem_data;
  logic          o_inst_mem_wr_en;
  logic          o_inst_mem_rst;
  logic          o_load_busy;
  logic          o_load_done;
  logic          o_load_err;
  logic [LW-1:0] o_word_count;
  state_e        dbg_state;

  inst_mem_loader #(.S_DATA_W(DW), .INST_LEN(W), .LEN_W(LW)) dut (
    .i_sys_clk       (clk),
    .i_sys_rst_n     (rst_n),
    .i_load_start    (i_load_start),
    .i_load_len      (i_load_len),
    .i_s_tdata       (i_s_tdata),
    .i_s_tvalid      (i_s_tvalid),
    .i_s_tlast       (i_s_tlast),
    .o_s_tready      (o_s_tready),
    .o_inst_mem_data (o_inst_mem_data),
    .o_inst_mem_wr_en(o_inst_mem_wr_en),
    .o_inst_mem_rst  (o_inst_mem_rst),
    .o_load_busy     (o_load_busy),
    .o_load_done     (o_load_done),
    .o_load_err      (o_load_err),
    .o_word_count    (o_word_count),
    .o_dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] exp_q[$];
  int           strobe_cnt = 0;
  int           rst_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout/unexpected expected=event", name);
  endtask

  // Every strobe must match the next expected word, in order.
  logic [W-1:0] mon_exp;
  always @(negedge clk) begin
    if (o_inst_mem_rst) rst_cnt++;
    if (o_inst_mem_wr_en) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        fail_now("strobe_unexpected");
      end else begin
        mon_exp = exp_q.pop_front();
        check("strobe_data", {32'd0, o_inst_mem_data}, {32'd0, mon_exp});
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    int len;
    int nbeats;
    int last_beat;   // 1-based beat carrying tlast, 0 = none
    int gap;         // idle cycles before each beat after the first
    bit poke;        // pulse i_load_start while busy
    int exp_strobes;
    bit exp_err;
    int base;
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver tasks ----------------
  task automatic send_beat(input int base, input int b, input bit last);
    int t;
    for (int l = 0; l < LANES; l++) i_s_tdata[l*W +: W] = W'(base + b*LANES + l);
    i_s_tlast  = last;
    i_s_tvalid = 1'b1;
    t = 0;
    while (!o_s_tready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      fail_now("beat_accept_timeout");
      i_s_tvalid = 1'b0;
    end else begin
      @(negedge clk);
      i_s_tvalid = 1'b0;
      i_s_tlast  = 1'b0;
      check("first_strobe_latency", {63'd0, o_inst_mem_wr_en}, 64'd1);
    end
  endtask

  task automatic run_load(input vec_t v);
    int s0, r0, t, tr, n_push;
    bit got_done;
    n_push = (v.len < v.nbeats*LANES) ? v.len : v.nbeats*LANES;
    for (int i = 0; i < n_push; i++) exp_q.push_back(W'(v.base + i));
    s0 = strobe_cnt;
    r0 = rst_cnt;
    got_done = 1'b0;
    tr = 0;

    @(negedge clk);
    i_load_start = 1'b1;
    i_load_len   = LW'(v.len);
    @(negedge clk);
    i_load_start = 1'b0;
    i_load_len   = LW'(7);
    check("rst_at_t1", {62'd0, o_inst_mem_rst, o_load_busy}, 64'd3);
    check("start_clears", {46'd0, o_load_err, o_word_count}, 64'd0);
    @(negedge clk);
    check("rst_one_cycle", {63'd0, o_inst_mem_rst}, 64'd0);
    if (v.len == 0) begin
      check("len0_done_t2", {61'd0, o_load_done, o_load_busy, o_s_tready}, 64'd4);
      got_done = 1'b1;
      check("done_err", {63'd0, o_load_err}, {63'd0, v.exp_err});
      check("done_count", {47'd0, o_word_count}, 64'(v.exp_strobes));
    end else begin
      check("tready_at_t2", {63'd0, o_s_tready}, 64'd1);
    end

    for (int b = 0; b < v.nbeats; b++) begin
      if (b > 0) repeat (v.gap) @(negedge clk);
      if (b == 1 && v.poke) begin
        i_load_start = 1'b1;
        i_load_len   = LW'(3);
        @(negedge clk);
        i_load_start = 1'b0;
      end
      send_beat(v.base, b, (b + 1) == v.last_beat);
    end

    // Offer a stray beat; the loader must not take it.
    for (int l = 0; l < LANES; l++) i_s_tdata[l*W +: W] = 32'hDEAD_0000 + W'(l);
    i_s_tvalid = 1'b1;
    t = 0;
    while (!got_done && t < 400) begin
      @(negedge clk);
      t++;
      if (o_s_tready) tr++;
      if (o_load_done) begin
        got_done = 1'b1;
        check("done_busy_low", {63'd0, o_load_busy}, 64'd0);
        check("done_err", {63'd0, o_load_err}, {63'd0, v.exp_err});
        check("done_count", {47'd0, o_word_count}, 64'(v.exp_strobes));
        if (n_push > 0) check("data_hold", {32'd0, o_inst_mem_data}, 64'(v.base + n_push - 1));
      end
    end
    if (!got_done) fail_now("done_timeout");
    repeat (2) begin
      @(negedge clk);
      if (o_s_tready) tr++;
    end
    i_s_tvalid = 1'b0;
    @(negedge clk);
    check("no_tready_after", 64'(tr), 64'd0);
    check("strobe_total", 64'(strobe_cnt - s0), 64'(v.exp_strobes));
    check("rst_pulses", 64'(rst_cnt - r0), 64'd1);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("err_sticky", {63'd0, o_load_err}, {63'd0, v.exp_err});
    exp_q.delete();
  endtask

  // ---------------- test ----------------
  initial begin
    //         len nb last gap poke strobes err base
    vecs[0] = '{16, 1, 1, 0, 1'b0, 16, 1'b0, 32'h0};
    vecs[1] = '{20, 2, 2, 0, 1'b0, 20, 1'b0, 32'h100};
    vecs[2] = '{40, 2, 2, 0, 1'b0, 32, 1'b1, 32'h200};
    vecs[3] = '{ 0, 0, 0, 0, 1'b0,  0, 1'b0, 32'h300};
    vecs[4] = '{ 5, 1, 0, 0, 1'b0,  5, 1'b1, 32'h400};
    vecs[5] = '{20, 2, 2, 5, 1'b1, 20, 1'b0, 32'h500};
    vecs[6] = '{32, 2, 2, 0, 1'b0, 32, 1'b0, 32'h600};
    vecs[7] = '{16, 1, 0, 0, 1'b0, 16, 1'b1, 32'h700};

    repeat (2) @(negedge clk);
    check("reset_outputs",
          {9'd0, o_s_tready, o_inst_mem_data, o_inst_mem_wr_en, o_inst_mem_rst,
           o_load_busy, o_load_done, o_load_err, o_word_count}, 64'd0);
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_load(vecs[i]);

    // Reset in the middle of draining a beat.
    for (int i = 0; i < 16; i++) exp_q.push_back(W'(32'h900 + i));
    @(negedge clk);
    i_load_start = 1'b1;
    i_load_len   = LW'(16);
    @(negedge clk);
    i_load_start = 1'b0;
    @(negedge clk);
    send_beat(32'h900, 0, 1'b1);
    repeat (3) @(negedge clk);
    check("mid_drain_state", 64'(dbg_state), 64'(ST_DRAIN));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {9'd0, o_s_tready, o_inst_mem_data, o_inst_mem_wr_en, o_inst_mem_rst,
           o_load_busy, o_load_done, o_load_err, o_word_count}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("no_strobe_after_reset", {63'd0, o_inst_mem_wr_en}, 64'd0);
    run_load('{16, 1, 1, 0, 1'b0, 16, 1'b0, 32'hA00});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
